// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient} for the EX-stage DIV/DIVU handshake.
// Optional macro DIV_EARLY_OUT_EN: jump straight to DONE when divisor == 0 or |dividend| < |divisor|.
//   state | meaning
//   IDLE  | waiting for start; operands latched on accept
//   BUSY  | one quotient bit per cycle, WIDTH cycles
//   DONE  | result_ok pulse, result register already holds the signed result
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 cancel,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 result_ok,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic                 busy_q, busy_d;
    logic                 ok_q, ok_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 in_neg_q, in_neg_r;
    logic [WIDTH:0]       shifted, trial;
    logic [WIDTH-1:0]     rem_next, quo_next, q_fix, r_fix;

    always_comb begin
        a_mag    = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag    = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
        in_neg_q = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        in_neg_r = signed_div & dividend[WIDTH-1];

        // rem < divisor always holds, so bit WIDTH of the trial is a valid sign bit
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr_q};
        quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_fix    = neg_q_q ? -quo_next : quo_next;
        r_fix    = neg_r_q ? -rem_next : rem_next;

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        busy_d   = busy_q;
        ok_d     = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    state_d = S_BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvsr_d  = b_mag;
                    neg_q_d = in_neg_q;
                    neg_r_d = in_neg_r;
`ifdef DIV_EARLY_OUT_EN
                    if (divisor == '0) begin
                        state_d  = S_DONE;
                        ok_d     = 1'b1;
                        result_d = {(in_neg_r ? -a_mag : a_mag),
                                    (in_neg_q ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}})};
                    end else if (a_mag < b_mag) begin
                        state_d  = S_DONE;
                        ok_d     = 1'b1;
                        result_d = {dividend, {WIDTH{1'b0}}};
                    end
`endif
                end
            end
            S_BUSY: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = S_DONE;
                        ok_d     = 1'b1;
                        result_d = {r_fix, q_fix};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            busy_q   <= busy_d;
            ok_q     <= ok_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign result_ok = ok_q;
    assign result    = result_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: stimulus pushes {result, completion cycle}, a monitor pops on result_ok.
module tb_iter_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        result_ok;
    logic [63:0] result;

    iter_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .cancel(cancel),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .result_ok(result_ok), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst && result_ok === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_ok", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("result_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    function automatic int lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm;
        am = (sgn && a[31]) ? -a : a;
        bm = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (b == 0 || am < bm) return 1;
`endif
        return (am == bm + 1) ? 33 : 33;
    endfunction

    task automatic push(input logic [63:0] res, input int at);
        exp_t e;
        e.res = res;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_waiting_result_ok", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        push(exp, cyc + lat(sgn, a, b));
        @(negedge clk);
        start      = 1'b0;
        signed_div = ~sgn;
        dividend   = 32'hDEAD_BEEF;
        divisor    = 32'h0000_0003;
        drain(60);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [63:0] prior;

        #3;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result_ok", 64'(result_ok), 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 100/7 with busy window checks
        t0 = cyc;
        signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        push({32'd2, 32'd14}, t0 + lat(1'b0, 32'd100, 32'd7));
        chk("busy_cycle0", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; dividend = 32'd1; divisor = 32'd1;
        chk("busy_cycle1", 64'(busy), 64'd1);
`ifndef DIV_EARLY_OUT_EN
        while (cyc < t0 + 33) @(negedge clk);
        chk("busy_cycle33", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_cycle34", 64'(busy), 64'd0);
`endif
        drain(60);

        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        run_div(1'b0, 32'h1234_5678, 32'h0000_0000, {32'h1234_5678, 32'hFFFF_FFFF});
        run_div(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'h0000_0001});
        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF});
`ifdef DIV_EARLY_OUT_EN
        run_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0});
        run_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
`endif

        // cancel mid-BUSY, then restart two cycles later
        prior = {32'h0000_000F, 32'h0FFF_FFFF};
        t0 = cyc;
        signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_cycle11", 64'(busy), 64'd0);
        chk("cancel_result_kept", result, prior);
        @(negedge clk);
        start = 1'b1;
        push({32'd1, 32'd333}, t0 + 45);
        @(negedge clk);
        start = 1'b0;
        drain(60);

        // asynchronous reset mid-BUSY
        t0 = cyc;
        signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 15) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_result_ok", 64'(result_ok), 64'd0);
        chk("async_rst_result", result, 64'd0);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_idle", 64'(busy), 64'd0);

        // back-to-back with start held; operands change after the first accept
        t0 = cyc;
        signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        push({32'd1, 32'd333}, t0 + 33);
        push({32'd2, 32'd14}, t0 + 67);
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7;
        while (cyc < t0 + 35) @(negedge clk);
        start = 1'b0;
        drain(80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
